// File: rtl/placement_reader.sv
// placement_reader: walks an N*N placement grid in row-major order and streams one record per occupied cell.
// Optional position-RAM cross-check is enabled with macro PLACEMENT_READER_CHECK_EN.
module placement_reader #(
    parameter int unsigned N     = 7,
    parameter int unsigned DW    = 32,
    parameter int unsigned NODES = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          reGrid,
    output logic [DW-1:0] addrGrid,
    input  logic [DW-1:0] doutGrid,
    output logic          rePX,
    output logic          rePY,
    output logic [DW-1:0] addrPX,
    output logic [DW-1:0] addrPY,
    input  logic [DW-1:0] doutPX,
    input  logic [DW-1:0] doutPY,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_node,
    output logic [DW-1:0] out_x,
    output logic [DW-1:0] out_y,
    output logic          out_mismatch,
    output logic [DW-1:0] cell_cnt,
    output logic [DW-1:0] mismatch_cnt
);

    localparam int unsigned   CELLS     = N * N;
    localparam logic [DW-1:0] LAST_ADDR = DW'(CELLS - 1);
    localparam logic [DW-1:0] LAST_Y    = DW'(N - 1);
    localparam logic [DW-1:0] EMPTY     = '1;
    // Node ids are passed through unchanged; the RAM depth only matters to the attached memories.
    localparam int unsigned   node_depth_unused = NODES;

    typedef enum logic [3:0] {
        IDLE,
        RD_GRID,
        WAIT_GRID,
        CHK_GRID,
        RD_POS,
        WAIT_POS,
        CMP,
        EMIT,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          accept;
    logic          handshake;
    logic          last_cell;
    logic          occupied;

    assign accept    = (state == IDLE) && start;
    assign handshake = (state == EMIT) && out_valid && out_ready;
    assign last_cell = (addrGrid == LAST_ADDR);
    assign occupied  = (doutGrid != EMPTY);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = RD_GRID;
            RD_GRID:   state_nxt = WAIT_GRID;
            WAIT_GRID: state_nxt = CHK_GRID;
            CHK_GRID: begin
                if (!occupied) begin
                    state_nxt = NEXT;
                end else begin
`ifdef PLACEMENT_READER_CHECK_EN
                    state_nxt = RD_POS;
`else
                    state_nxt = EMIT;
`endif
                end
            end
            RD_POS:    state_nxt = WAIT_POS;
            WAIT_POS:  state_nxt = CMP;
            CMP:       state_nxt = EMIT;
            EMIT:      if (out_valid && out_ready) state_nxt = NEXT;
            NEXT:      state_nxt = last_cell ? DONE : RD_GRID;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Status, grid strobe, scan position, record fields and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            reGrid       <= 1'b0;
            out_valid    <= 1'b0;
            addrGrid     <= '0;
            x            <= '0;
            y            <= '0;
            out_node     <= '0;
            out_x        <= '0;
            out_y        <= '0;
            cell_cnt     <= '0;
            mismatch_cnt <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            reGrid    <= (state_nxt == RD_GRID);
            out_valid <= (state_nxt == EMIT);

            if (accept) begin
                addrGrid     <= '0;
                x            <= '0;
                y            <= '0;
                cell_cnt     <= '0;
                mismatch_cnt <= '0;
            end

            // y is the inner loop, so the linear address simply increments
            if (state == NEXT && !last_cell) begin
                addrGrid <= addrGrid + DW'(1);
                if (y == LAST_Y) begin
                    y <= '0;
                    x <= x + DW'(1);
                end else begin
                    y <= y + DW'(1);
                end
            end

            if (state == CHK_GRID && occupied) begin
                out_node <= doutGrid;
                out_x    <= x;
                out_y    <= y;
            end

            if (handshake) begin
                cell_cnt     <= cell_cnt + DW'(1);
                mismatch_cnt <= mismatch_cnt + DW'(out_mismatch);
            end
        end
    end

`ifdef PLACEMENT_READER_CHECK_EN
    // Position lookup for the node just read, compared against the cell coordinates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rePX         <= 1'b0;
            rePY         <= 1'b0;
            addrPX       <= '0;
            addrPY       <= '0;
            out_mismatch <= 1'b0;
        end else begin
            rePX <= (state_nxt == RD_POS);
            rePY <= (state_nxt == RD_POS);
            if (state == CHK_GRID && occupied) begin
                addrPX <= doutGrid;
                addrPY <= doutGrid;
            end
            if (state == CMP) begin
                out_mismatch <= (doutPX != out_x) || (doutPY != out_y);
            end
        end
    end
`else
    assign rePX         = 1'b0;
    assign rePY         = 1'b0;
    assign addrPX       = '0;
    assign addrPY       = '0;
    assign out_mismatch = 1'b0;

    logic pos_data_unused;
    assign pos_data_unused = ^{doutPX, doutPY};
`endif

endmodule

// File: tb/tb_placement_reader.sv
// tb_placement_reader: drives randomized grids through placement_reader and checks the record stream,
// counters and strobes against a queue model built directly from the grid contents.
`timescale 1ns/1ps
module tb_placement_reader;

    localparam int unsigned N     = 7;
    localparam int unsigned DW    = 32;
    localparam int unsigned NODES = 128;
    localparam int unsigned CELLS = N * N;
    localparam int          LIMIT = 4000;
`ifdef PLACEMENT_READER_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    localparam logic [DW-1:0] EMPTY = '1;

    typedef struct {
        logic [DW-1:0] node;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          mm;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          reGrid;
    logic [DW-1:0] addrGrid;
    logic [DW-1:0] doutGrid;
    logic          rePX;
    logic          rePY;
    logic [DW-1:0] addrPX;
    logic [DW-1:0] addrPY;
    logic [DW-1:0] doutPX;
    logic [DW-1:0] doutPY;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_node;
    logic [DW-1:0] out_x;
    logic [DW-1:0] out_y;
    logic          out_mismatch;
    logic [DW-1:0] cell_cnt;
    logic [DW-1:0] mismatch_cnt;

    placement_reader #(.N(N), .DW(DW), .NODES(NODES)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .reGrid       (reGrid),
        .addrGrid     (addrGrid),
        .doutGrid     (doutGrid),
        .rePX         (rePX),
        .rePY         (rePY),
        .addrPX       (addrPX),
        .addrPY       (addrPY),
        .doutPX       (doutPX),
        .doutPY       (doutPY),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_node     (out_node),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_mismatch (out_mismatch),
        .cell_cnt     (cell_cnt),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    // Memories with a two-cycle read latency
    logic [DW-1:0] grid_mem [CELLS];
    logic [DW-1:0] px_mem   [NODES];
    logic [DW-1:0] py_mem   [NODES];
    logic [DW-1:0] g_s1, px_s1, py_s1;

    always @(posedge clk) begin
        if (reGrid) g_s1 <= grid_mem[6'(addrGrid)];
        if (rePX)   px_s1 <= px_mem[7'(addrPX)];
        if (rePY)   py_s1 <= py_mem[7'(addrPY)];
        doutGrid <= g_s1;
        doutPX   <= px_s1;
        doutPY   <= py_s1;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t exp_q[$];
    int   ready_mode = 0;
    bit   mon_en = 1'b0;
    int   grid_reads, pos_reads, done_cnt, recs;
    bit   prev_re, held_v;
    rec_t held, r_mon;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Stream and strobe monitor
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mon_en && !reset) begin
            if (reGrid) begin
                check("grid_addr_seq", addrGrid, DW'(grid_reads));
                check("grid_strobe_pulse", DW'(prev_re), 0);
                grid_reads++;
            end
            if (rePX || rePY) begin
                check("pos_strobe_pair", DW'(rePY), DW'(rePX));
                check("pos_addr_pair", addrPY, addrPX);
                pos_reads++;
            end
            if (out_valid) begin
                if (held_v) begin
                    check("stall_node", out_node, held.node);
                    check("stall_x", out_x, held.x);
                    check("stall_y", out_y, held.y);
                    check("stall_mm", DW'(out_mismatch), DW'(held.mm));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_record", DW'(out_valid), 0);
                    end else begin
                        r_mon = exp_q.pop_front();
                        check("rec_node", out_node, r_mon.node);
                        check("rec_x", out_x, r_mon.x);
                        check("rec_y", out_y, r_mon.y);
                        check("rec_mismatch", DW'(out_mismatch), DW'(r_mon.mm));
                    end
                    recs++;
                    held_v = 1'b0;
                end else begin
                    held_v    = 1'b1;
                    held.node = out_node;
                    held.x    = out_x;
                    held.y    = out_y;
                    held.mm   = out_mismatch;
                end
            end else begin
                held_v = 1'b0;
            end
        end
        prev_re = reGrid;
    end

    // Reference model: one record per non-empty cell, in address order
    task automatic build_expect(output int occ, output int mmc);
        exp_q.delete();
        occ = 0;
        mmc = 0;
        for (int a = 0; a < int'(CELLS); a++) begin
            rec_t r;
            if (grid_mem[a] != EMPTY) begin
                r.node = grid_mem[a];
                r.x    = DW'(a / int'(N));
                r.y    = DW'(a % int'(N));
                r.mm   = CHECK && ((px_mem[7'(r.node)] != r.x) || (py_mem[7'(r.node)] != r.y));
                exp_q.push_back(r);
                occ++;
                if (r.mm) mmc++;
            end
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < int'(CELLS); a++) grid_mem[a] = EMPTY;
        for (int n = 0; n < int'(NODES); n++) begin
            px_mem[n] = '0;
            py_mem[n] = '0;
        end
    endtask

    task automatic random_fill();
        clear_mem();
        for (int a = 0; a < int'(CELLS); a++) begin
            if ($urandom_range(0, 99) < 35) begin
                int unsigned nd;
                nd = $urandom_range(0, NODES - 1);
                grid_mem[a] = DW'(nd);
                if ($urandom_range(0, 3) != 0) begin
                    px_mem[nd] = DW'(a / int'(N));
                    py_mem[nd] = DW'(a % int'(N));
                end else begin
                    px_mem[nd] = DW'($urandom_range(0, N - 1));
                    py_mem[nd] = DW'($urandom_range(0, N - 1));
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, DW'({busy, done, reGrid, rePX, rePY, out_valid, out_mismatch}), 0);
        check({tag, "_addr"}, addrGrid | addrPX | addrPY, 0);
        check({tag, "_fields"}, out_node | out_x | out_y, 0);
        check({tag, "_cnt"}, cell_cnt | mismatch_cnt, 0);
    endtask

    task automatic run_scan(input bit mid_start, input bit bp);
        int occ, mmc, cyc, stall;
        bit pulsed;
        build_expect(occ, mmc);
        grid_reads = 0;
        pos_reads  = 0;
        done_cnt   = 0;
        recs       = 0;
        held_v     = 1'b0;
        pulsed     = 1'b0;
        stall      = 0;
        mon_en     = 1'b1;
        if (bp) ready_mode = 2;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", DW'(busy), 1);
        check("cnt_cleared", cell_cnt | mismatch_cnt, 0);
        cyc = 0;
        while (done_cnt == 0 && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (mid_start && !pulsed && addrGrid == DW'(30)) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (bp && ready_mode == 2 && out_valid) begin
                stall++;
                if (stall == 5) begin
                    check("bp_valid_held", DW'(out_valid), 1);
                    check("bp_cnt_held", cell_cnt, 0);
                    ready_mode = 0;
                end
            end
            cyc++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("done_pulses", DW'(done_cnt), 1);
        check("busy_idle", DW'(busy), 0);
        check("records", DW'(recs), DW'(occ));
        check("queue_drained", DW'(exp_q.size()), 0);
        check("cell_cnt", cell_cnt, DW'(occ));
        check("mismatch_cnt", mismatch_cnt, DW'(mmc));
        check("grid_reads", DW'(grid_reads), DW'(CELLS));
        check("pos_reads", DW'(pos_reads), CHECK ? DW'(occ) : 0);
    endtask

    task automatic reset_mid_scan(input bit in_emit);
        int cyc;
        mon_en = 1'b0;
        random_fill();
        if (in_emit) begin
            grid_mem[5] = DW'(9);
            ready_mode  = 2;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        if (in_emit) begin
            while (!out_valid && cyc < LIMIT) begin @(negedge clk); cyc++; end
            check("reached_emit", DW'(out_valid), 1);
        end else begin
            while (!(reGrid && addrGrid == DW'(20)) && cyc < LIMIT) begin @(negedge clk); cyc++; end
            check("reached_cell20", DW'(reGrid), 1);
        end
        #1 reset = 1'b1;
        #1;
        check_zero(in_emit ? "rst_emit" : "rst_cell20");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        ready_mode = 0;
        done_cnt   = 0;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", DW'(done_cnt), 0);
        check("idle_after_rst", DW'({busy, out_valid, reGrid}), 0);
        held_v = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        clear_mem();
        #2 reset = 1'b1;
        #1;
        check_zero("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single node at cell 18 = (2,4)
        clear_mem();
        grid_mem[18] = DW'(3);
        px_mem[3]    = DW'(2);
        py_mem[3]    = DW'(4);
        run_scan(1'b0, 1'b0);

        // Empty grid
        clear_mem();
        run_scan(1'b0, 1'b0);

        // Backpressure on the single record
        clear_mem();
        grid_mem[18] = DW'(3);
        px_mem[3]    = DW'(2);
        py_mem[3]    = DW'(4);
        run_scan(1'b0, 1'b1);

        // Position disagrees with the grid
        px_mem[3] = DW'(1);
        run_scan(1'b0, 1'b0);

        // Reset during the scan, then a clean rescan
        reset_mid_scan(1'b0);
        run_scan(1'b0, 1'b0);
        reset_mid_scan(1'b1);
        run_scan(1'b0, 1'b0);

        // Start pulsed while busy
        random_fill();
        run_scan(1'b1, 1'b0);

        // Random grids with random backpressure
        for (int i = 0; i < 6; i++) begin
            random_fill();
            ready_mode = 1;
            run_scan(1'b0, 1'b0);
        end
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
